delay_line_pipe: RTL

Parametrised, stallable delay line that carries a WIDTH-bit sample stream with per-stage valid tracking. It provides two outputs:

- a fixed one-cycle tap;
- a tap whose delay is runtime-selectable from 1 to DEPTH cycles.

When the selected delay changes, the block masks the programmable output until the pipeline has refilled. It sits between a sample source and any consumer that needs time-aligned, delay-compensated data.

---
 rtl/delay_line_pkg.sv | 7 +
 rtl/delay_line_pipe_if.sv | 22 ++
 rtl/delay_tap_mux.sv | 16 +
 rtl/delay_line_pipe.sv | 60 ++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// delay_line_pkg: shared state type and delay clamp for the delay line
package delay_line_pkg;
  typedef enum logic {RUN, SETTLE} state_t;
  function automatic int clamp(input int sel, input int depth);
    return sel < 1 ? 1 : (sel > depth ? depth : sel);
  endfunction
endpackage

// File: rtl/delay_line_pipe_if.sv
// delay_line_pipe_if: sample stream, control and tap outputs of the delay line
interface delay_line_pipe_if #(parameter int WIDTH = 4, parameter int DEPTH = 8);
  localparam int DW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             en;
  logic             flush;
  logic [DW-1:0]    dly_sel;
  logic [WIDTH-1:0] out1;
  logic             out1_valid;
  logic [WIDTH-1:0] out2;
  logic             out2_valid;
  logic             settling;
  modport master (
    output in_data, in_valid, en, flush, dly_sel,
    input  out1, out1_valid, out2, out2_valid, settling
  );
  modport slave (
    input  in_data, in_valid, en, flush, dly_sel,
    output out1, out1_valid, out2, out2_valid, settling
  );
endinterface

// File: rtl/delay_tap_mux.sv
// delay_tap_mux: picks stage sel (1-based) out of n packed taps
module delay_tap_mux #(
  parameter int W  = 5,
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic [N-1:0][W-1:0] taps,
  input  logic [SW-1:0]       sel,
  output logic [W-1:0]        y
);
  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++)
      if (sel == SW'(k + 1)) y = taps[k];
  end
endmodule

// File: rtl/delay_line_pipe.sv
// delay_line_pipe: stallable delay line with fixed 1-cycle tap and masked programmable tap
module delay_line_pipe
  import delay_line_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst_n,
  delay_line_pipe_if.slave bus
);
  logic [DEPTH-1:0][WIDTH:0] s;
  logic [DW-1:0] dly_q, dly_d, cnt, cnt_d, sel_c;
  logic [WIDTH:0] tap;
  logic change;
  state_t state, state_d;
  assign sel_c  = DW'(clamp(int'(bus.dly_sel), DEPTH));
  assign change = sel_c != dly_q;
  // a fresh change always restarts the settle count, flush overrides it
  always_comb begin
    dly_d   = change ? sel_c : dly_q;
    state_d = state;
    cnt_d   = cnt;
    if (bus.flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (change) begin
      state_d = SETTLE;
      cnt_d   = sel_c;
    end else if (state == SETTLE && bus.en) begin
      cnt_d   = cnt - 1'b1;
      state_d = cnt == DW'(1) ? RUN : SETTLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
      dly_q <= DW'(1);
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      dly_q <= dly_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else if (bus.flush) s <= '0;
    else if (bus.en) s <= {s[DEPTH-2:0], {bus.in_valid, bus.in_data}};
  delay_tap_mux #(.W(WIDTH + 1), .N(DEPTH), .SW(DW)) u_mux (
    .taps(s),
    .sel (dly_q),
    .y   (tap)
  );
  assign bus.out1       = s[0][WIDTH-1:0];
  assign bus.out1_valid = s[0][WIDTH];
  assign bus.settling   = state == SETTLE;
  assign bus.out2       = tap[WIDTH-1:0];
  assign bus.out2_valid = tap[WIDTH] & ~bus.settling;
endmodule
